// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and types for the data-memory access controller.
// Holds the bus width, clock period, default timeout and FSM encoding.
package mem_access_ctrl_pkg;

    localparam int WORD            = 64;
    localparam int CYCLE           = 10;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Memory accesses are doubleword-wide; any low address bit set is an error.
    function automatic logic is_aligned(input logic [WORD-1:0] addr);
        return (addr[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, memory-strobe and response signals of the data-memory port.
// master = the controller, slave = execute stage plus memory responder.
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int W = WORD
);

    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;
    logic         stall;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata, rsp_ready,
        output req_ready, mem_read, mem_write, mem_addr, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata, rsp_ready,
        input  req_ready, mem_read, mem_write, mem_addr, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err, stall
    );

endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Saturating strobe-cycle counter; expired flags the final allowed strobe cycle.
// With TIMEOUT=1 the very first strobe cycle is already the last one.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_r;

    // Count unacknowledged strobe cycles, holding at CNT_MAX instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r >= CNT_LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: one load/store at a time, strobes held until ack or
// timeout, then a held response. Every bus output comes straight from a flop.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.master  bus
);

    state_t            state_r;
    logic              req_ready_r;
    logic              write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [WORD-1:0]   mem_addr_r;
    logic [WORD-1:0]   mem_wdata_r;
    logic              rsp_valid_r;
    logic [WORD-1:0]   rsp_rdata_r;
    logic              rsp_err_r;
    logic              stall_r;

    logic              cnt_clear_s;
    logic              cnt_enable_s;
    logic              timeout_s;

    assign cnt_clear_s  = (state_r == IDLE);
    assign cnt_enable_s = (state_r == ISSUE) && !bus.mem_ack;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (timeout_s)
    );

    // Request/response FSM; outputs are set on the edge that enters each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            write_r     <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            stall_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        mem_addr_r  <= bus.req_addr;
                        mem_wdata_r <= bus.req_wdata;
                        write_r     <= bus.req_write;
                        req_ready_r <= 1'b0;
                        stall_r     <= 1'b1;
                        if (is_aligned(bus.req_addr)) begin
                            state_r     <= ISSUE;
                            mem_read_r  <= !bus.req_write;
                            mem_write_r <= bus.req_write;
                        end else begin
                            // Misaligned: answer with an error, memory never sees it.
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= '0;
                            rsp_err_r   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ack) begin
                        state_r     <= RESP;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= write_r ? '0 : bus.mem_rdata;
                        rsp_err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        state_r     <= RESP;
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        stall_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= '0;
                    rsp_err_r   <= 1'b0;
                    stall_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.mem_read  = mem_read_r;
    assign bus.mem_write = mem_write_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.stall     = stall_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, random
// transactions against a transaction-level model, plus reset/backpressure cases.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #(CYCLE / 2) clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          delay;      // wait cycles before ack; >= TO means no ack in time
        logic [63:0] rdata;
        int          hold;       // extra cycles rsp_ready stays low
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_strobes;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome follows from alignment and ack delay alone.
    task automatic model(input vec_t v, output logic err, output logic [63:0] rd, output int strobes);
        if (v.addr % 8 != 0) begin
            err = 1'b1; rd = 64'd0; strobes = 0;
        end else if (v.delay >= TO) begin
            err = 1'b1; rd = 64'd0; strobes = TO;
        end else begin
            err = 1'b0; rd = v.wr ? 64'd0 : v.rdata; strobes = v.delay + 1;
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   strobes   = 0;
        int   lat       = 0;
        bit   seen      = 0;
        bit   bad_type  = 0;
        bit   bad_hold  = 0;
        bit   bad_stall = 0;
        bit   both      = 0;
        int   exp_lat;
        @(negedge clk);
        check($sformatf("%s req_ready idle", tag), bus.req_ready, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.rsp_ready = (v.hold == 0);
        bus.mem_ack   = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_read && bus.mem_write) both = 1;
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                if (bus.mem_write !== v.wr) bad_type = 1;
                if (bus.mem_addr !== v.addr) bad_hold = 1;
                if (v.wr && bus.mem_wdata !== v.wdata) bad_hold = 1;
            end
            if (bus.stall !== 1'b1) bad_stall = 1;
            if (bus.rsp_valid === 1'b1) begin
                seen = 1;
                lat  = k;
            end
            if (seen) begin
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = {$urandom, $urandom};
            end else begin
                bus.mem_ack   = (bus.mem_read || bus.mem_write) && (strobes == v.delay + 1);
                bus.mem_rdata = bus.mem_ack ? v.rdata : {$urandom, $urandom};
            end
        end
        exp_lat = v.exp_strobes + 1;
        check($sformatf("%s strobe cycles", tag), 64'(strobes), 64'(v.exp_strobes));
        check($sformatf("%s rsp latency", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s rsp_err", tag), bus.rsp_err, v.exp_err);
        check($sformatf("%s rsp_rdata", tag), bus.rsp_rdata, v.exp_rdata);
        check($sformatf("%s strobe kind/both", tag), {bad_type, both}, 64'd0);
        check($sformatf("%s mem_addr/wdata stable", tag), bad_hold, 64'd0);
        check($sformatf("%s stall in flight", tag), bad_stall, 64'd0);
        check($sformatf("%s req_ready busy", tag), bus.req_ready, 64'd0);
        if (v.hold > 0) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = 64'h40;
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            bus.mem_ack = 1'($urandom_range(0, 1));
            check($sformatf("%s hold%0d rsp_valid", tag, h), bus.rsp_valid, 64'd1);
            check($sformatf("%s hold%0d rsp_rdata", tag, h), bus.rsp_rdata, v.exp_rdata);
            check($sformatf("%s hold%0d rsp_err", tag, h), bus.rsp_err, v.exp_err);
            check($sformatf("%s hold%0d no accept", tag, h),
                  {bus.req_ready, bus.mem_read, bus.mem_write}, 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check($sformatf("%s back to idle", tag),
              {bus.rsp_valid, bus.req_ready, bus.stall}, 64'b010);
    endtask

    vec_t table_v[9];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr    addr      wdata      delay rdata                   hold err  rdata                   strobes
        table_v[0] = '{1'b0, 64'h08, 64'h0,    0,  64'd1234,               0, 1'b0, 64'd1234,               1};
        table_v[1] = '{1'b1, 64'h10, 64'hDEAD, 3,  64'h1111,               0, 1'b0, 64'd0,                  4};
        table_v[2] = '{1'b0, 64'h20, 64'h0,    99, 64'h2222,               0, 1'b1, 64'd0,                  15};
        table_v[3] = '{1'b0, 64'h28, 64'h0,    14, 64'h55,                 0, 1'b0, 64'h55,                 15};
        table_v[4] = '{1'b0, 64'h02, 64'h0,    0,  64'h3333,               0, 1'b1, 64'd0,                  0};
        table_v[5] = '{1'b0, 64'h30, 64'h0,    1,  64'hABCD,               5, 1'b0, 64'hABCD,               2};
        table_v[6] = '{1'b1, 64'h38, 64'hBEEF, 99, 64'h4444,               0, 1'b1, 64'd0,                  15};
        table_v[7] = '{1'b1, 64'h07, 64'h77,   0,  64'h5555,               2, 1'b1, 64'd0,                  0};
        table_v[8] = '{1'b0, 64'h48, 64'h0,    13, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 14};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'd0;
        bus.req_wdata = 64'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'd0;
        bus.rsp_ready = 1'b1;

        #(CYCLE * 2 + 2);
        check("reset outputs low",
              {bus.mem_read, bus.mem_write, bus.rsp_valid, bus.rsp_err, bus.stall}, 64'd0);
        check("reset req_ready", bus.req_ready, 64'd1);
        check("reset mem_addr", bus.mem_addr, 64'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(table_v[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a strobe phase
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h50;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("pre-reset mem_read", {bus.mem_read, bus.stall}, 64'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async reset strobes/stall/rsp",
              {bus.mem_read, bus.mem_write, bus.stall, bus.rsp_valid}, 64'd0);
        check("async reset req_ready", bus.req_ready, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(table_v[0], "post-reset load");
        run_txn(table_v[2], "post-reset timeout");

        for (int i = 0; i < 30; i++) begin
            rv.wr    = 1'($urandom_range(0, 1));
            rv.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rv.addr[2:0] = 3'b000;
            rv.wdata = {$urandom, $urandom};
            rv.delay = $urandom_range(0, 20);
            rv.rdata = {$urandom, $urandom};
            rv.hold  = $urandom_range(0, 3);
            model(rv, rv.exp_err, rv.exp_rdata, rv.exp_strobes);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator side of the data-memory port: accepts one load/store request at a time from the execute stage and drives `mem_read`/`mem_write`, address and write data toward the memory responder. It holds the strobes until the responder acknowledges, bounded by a timeout, then returns load data or an error on a response handshake. It sits between the ALU result/register-read datapath and the data memory, and its `stall` output freezes the upstream pipeline while an access is in flight.

## Interface
- `WORD`, 64 (from `definitions.vh`): data and address width.
- `TIMEOUT`, 15: maximum strobe cycles without `mem_ack` before an error response (≥1).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock domain only.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  WORD  byte address (ALU result).
- `req_wdata`  in  WORD  store data (read_data2).
- `mem_read`  out  1  load strobe to memory.
- `mem_write`  out  1  store strobe to memory.
- `mem_addr`  out  WORD  registered address.
- `mem_wdata`  out  WORD  registered store data.
- `mem_ack`  in  1  responder done; `mem_rdata` valid on loads.
- `mem_rdata`  in  WORD  load data from memory.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  WORD  load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or timed out.
- `stall`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture addr, wdata and write.
  - If `req_addr[2:0]` ≠ 0, go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No strobe is ever raised.
  - Otherwise go to ISSUE and clear the timeout count.
- ISSUE: exactly one of `mem_read`/`mem_write` is high. `mem_addr`/`mem_wdata` are stable.
  - `mem_ack`=1: capture `mem_rdata` (loads) or 0 (stores), `rsp_err`=0, go to RESP.
  - No ack: increment the count. If this was strobe cycle number `TIMEOUT`, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - Ack in the same cycle as timeout: ack wins, no error.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` are held stable until `rsp_ready`. On `rsp_ready`, go to IDLE.
- `mem_ack` is ignored in IDLE and RESP.
- `mem_read` and `mem_write` are never both high.
- Reset (async, any state): state→IDLE. All outputs are 0 except `req_ready`=1. `stall`=0. Count=0. An in-flight access is abandoned with no response.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Request accepted at edge N (IDLE, `req_valid`):
  - Strobes high from N+1.
  - Zero-wait ack sampled at edge N+1 → `rsp_valid` from N+2.
- Wait states add one cycle each. Strobes drop on the same edge that `rsp_valid` rises.
- Timeout: strobes high for exactly `TIMEOUT` cycles, then `rsp_valid` with err.
- Misaligned request: `rsp_valid` at N+1, no strobe.
- `rsp_ready` held high: RESP lasts 1 cycle, and IDLE lasts at least 1 cycle. Peak throughput is one access per 3 cycles.
- `stall` rises at N+1 and falls on the edge leaving RESP.

## Structure
- State encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and default `TIMEOUT` go in the shared `definitions.vh` alongside `WORD`/`CYCLE`.
- Sub-module `mem_timeout_cnt`: clear, enable and `TIMEOUT` parameter; outputs `expired`. Instantiated once.
- Top level holds the FSM, request/response registers and strobe decode.

## Test plan
- Aligned load, addr=8, ack on first ISSUE cycle with `mem_rdata`=1234 → `mem_read` high exactly 1 cycle; `rsp_valid` at N+2 with `rsp_rdata`=1234, `rsp_err`=0.
- Store, addr=16, wdata=0xDEAD, ack after 3 wait cycles → `mem_write` high 4 cycles with `mem_wdata`=0xDEAD; response `rsp_rdata`=0, `rsp_err`=0; `stall` high throughout.
- Load with no ack, `TIMEOUT`=15 → `mem_read` high exactly 15 cycles; then `rsp_err`=1, `rsp_rdata`=0. A repeat case with ack on cycle 15 gives `rsp_err`=0.
- Misaligned load, addr=2 → no strobe ever; `rsp_valid` at N+1 with `rsp_err`=1.
- `rsp_ready` low for 5 cycles → `rsp_valid`/`rsp_rdata` stable all 5 cycles; `req_ready` stays 0; a new `req_valid` is not accepted.
- `rst_n` pulsed low mid-ISSUE between edges → strobes, `stall` and `rsp_valid` go to 0 immediately, `req_ready`=1; the next request proceeds normally.
